// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for sram_ctrl: FSM state encoding, access-size codes
// and the word width the lane logic is built for.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WORD_W = 32;

  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/sram_ctrl_lane.sv
// Little-endian lane handling: extracts and extends load data from an SRAM word,
// and merges right-aligned store data into the word read back for sub-word stores.
module sram_ctrl_lane
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_addr_lo,
  input  logic [WORD_W-1:0] i_ld_word,
  input  logic [WORD_W-1:0] i_rmw_word,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_ld_data,
  output logic [WORD_W-1:0] o_st_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half accesses use only addr[1]; addr[0] is don't-care unless rejected upstream.
  assign w_byte = i_ld_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_ld_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_size)
      SZ_BYTE: o_ld_data = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      SZ_HALF: o_ld_data = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

  always_comb begin
    o_st_data = i_rmw_word;
    case (i_size)
      SZ_BYTE: o_st_data[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_HALF: o_st_data[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_st_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM load/store controller; sub-word stores use read-modify-write.
// Define SRAM_CTRL_ALIGN_CHECK_EN to reject misaligned half and word accesses.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 10240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              sram_cs,
  output logic              sram_rd,
  output logic              sram_wr,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [DWIDTH-1:0] sram_din,
  input  logic [DWIDTH-1:0] sram_dout
);

  localparam logic [AWIDTH-1:0] DEPTH_W = AWIDTH'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_rmw_word;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_oob;
  logic              w_misalign;
  logic              w_err;
  logic [DWIDTH-1:0] w_ld_data;
  logic [DWIDTH-1:0] w_st_data;

  assign w_accept = req_valid && req_ready;
  assign w_oob    = {2'b00, req_addr[AWIDTH-1:2]} >= DEPTH_W;

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (req_size == SZ_RSVD) || w_oob || w_misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Strobes are a pure decode of state so errors never touch the SRAM.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    sram_cs     = 1'b0;
    sram_rd     = 1'b0;
    sram_wr     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                 w_state_nxt = RESP;
          else if (!req_we)          w_state_nxt = RD;
          else if (is_subword(req_size)) w_state_nxt = RMW_RD;
          else                       w_state_nxt = WR;
        end
      end
      RD: begin
        sram_cs     = 1'b1;
        sram_rd     = 1'b1;
        w_state_nxt = RESP;
      end
      RMW_RD: begin
        sram_cs     = 1'b1;
        sram_rd     = 1'b1;
        w_state_nxt = WR;
      end
      WR: begin
        sram_cs     = 1'b1;
        sram_wr     = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rmw_word <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
        r_err    <= w_err;
      end
      if (r_state == RD)     r_rdata    <= w_ld_data;
      if (r_state == RMW_RD) r_rmw_word <= sram_dout;
    end
  end

  sram_ctrl_lane u_lane (
    .i_size     (r_size),
    .i_signed   (r_signed),
    .i_addr_lo  (r_addr[1:0]),
    .i_ld_word  (sram_dout),
    .i_rmw_word (r_rmw_word),
    .i_wdata    (r_wdata),
    .o_ld_data  (w_ld_data),
    .o_st_data  (w_st_data)
  );

  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign resp_err   = resp_valid & r_err;
  assign sram_addr  = {r_addr[AWIDTH-1:2], 2'b00};
  // Word stores bypass the merge; the lane passes r_wdata through for SZ_WORD.
  assign sram_din   = r_we ? w_st_data : w_st_data;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural asynchronous-read SRAM.
module tb_sram_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 10240;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          sram_cs, sram_rd, sram_wr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  sram_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .sram_cs    (sram_cs),
    .sram_rd    (sram_rd),
    .sram_wr    (sram_wr),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [13:0] idx;

  assign idx       = sram_addr[15:2];
  assign sram_dout = (sram_cs && sram_rd && (int'(idx) < DEPTH)) ? mem[idx] : 32'h5A5A5A5A;

  always @(posedge clk) begin
    if (sram_cs && sram_wr && (int'(idx) < DEPTH)) mem[idx] <= sram_din;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ncs;
    int          nwr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'b11) || (addr[31:2] >= 30'd10240);
    if (ALIGN && (((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00))))
      e = 1'b1;
    return e;
  endfunction

  // Builds the expected response and applies any store to the reference memory.
  task automatic build_exp(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          wi;
    e.err   = model_err(size, addr);
    e.rdata = 32'h0;
    e.addr  = {addr[31:2], 2'b00};
    e.nwr   = 0;
    e.lat   = 1;
    e.ncs   = 0;
    if (!e.err) begin
      wi = int'(addr[31:2]);
      w  = ref_mem[wi];
      b  = w[8*addr[1:0] +: 8];
      h  = addr[1] ? w[31:16] : w[15:0];
      if (!we) begin
        e.lat = 2;
        e.ncs = 1;
        case (size)
          2'b00:   e.rdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
          2'b01:   e.rdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
          default: e.rdata = w;
        endcase
      end else begin
        e.nwr = 1;
        case (size)
          2'b00: begin w[8*addr[1:0] +: 8] = wdata[7:0]; e.lat = 3; e.ncs = 2; end
          2'b01: begin w[16*addr[1] +: 16] = wdata[15:0]; e.lat = 3; e.ncs = 2; end
          default: begin w = wdata; e.lat = 2; e.ncs = 1; end
        endcase
        ref_mem[wi] = w;
      end
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h0;
  endtask

  task automatic get_resp(input int hold);
    exp_t        e;
    int          lat, ncs, nwr;
    logic [31:0] rd0;
    logic        er0;
    e   = sb_q.pop_front();
    lat = 1;
    ncs = 0;
    nwr = 0;
    while (!resp_valid && lat < 8) begin
      if (sram_cs) begin
        ncs++;
        check_eq("sram_addr", sram_addr, e.addr);
      end
      if (sram_wr) nwr++;
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("resp_valid", 32'(resp_valid), 32'd1);
    check_eq("resp_rdata", resp_rdata, e.rdata);
    check_eq("resp_err", 32'(resp_err), 32'(e.err));
    check_eq("latency", 32'(lat), 32'(e.lat));
    check_eq("cs_cycles", 32'(ncs), 32'(e.ncs));
    check_eq("wr_cycles", 32'(nwr), 32'(e.nwr));
    rd0        = resp_rdata;
    er0        = resp_err;
    last_rdata = resp_rdata;
    last_err   = resp_err;
    last_lat   = lat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_rdata", resp_rdata, rd0);
      check_eq("hold_err", 32'(resp_err), 32'(er0));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_cs", 32'(sram_cs), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("post_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    exp_t e;
    build_exp(we, size, sgn, addr, wdata, e);
    sb_q.push_back(e);
    send(we, size, sgn, addr, wdata);
    get_resp(hold);
  endtask

  task automatic chk_idle();
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_strobes", 32'({sram_cs, sram_rd, sram_wr}), 32'd0);
    check_eq("rst_sram_addr", sram_addr, 32'h0);
    check_eq("rst_sram_din", sram_din, 32'h0);
  endtask

  initial begin
    exp_t dummy;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     <= {16'hA5A5, 16'(i)};
      ref_mem[i]  = {16'hA5A5, 16'(i)};
    end

    repeat (3) @(posedge clk);
    #1;
    chk_idle();
    rst_n = 1'b1;

    // Word store then signed byte load of the top lane.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    check_eq("sbyte_load_value", last_rdata, 32'hFFFFFFDE);
    check_eq("sbyte_load_lat", 32'(last_lat), 32'd2);

    // Half store merges into the upper lanes only.
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 0);
    check_eq("half_store_lat", 32'(last_lat), 32'd3);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check_eq("rmw_word_value", last_rdata, 32'h1234BEEF);

    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check_eq("byte_merge_value", last_rdata, 32'h1234ABEF);

    // Errors: out of range and reserved size; neither may write.
    do_req(1'b0, 2'b10, 1'b0, 32'h0000A000, 32'h0, 0);
    check_eq("oob_err", 32'(last_err), 32'd1);
    check_eq("oob_lat", 32'(last_lat), 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h30, 32'h11111111, 0);
    check_eq("rsvd_err", 32'(last_err), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h00009FFC, 32'h0, 0);

    // Backpressure on the response.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3);

    // Misaligned accesses.
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 0);

    for (int n = 0; n < 24; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             32'h40 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));
    end

    // Reset during RMW_RD must not write.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 0);
    send(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000077);
    check_eq("rmw_rd_strobes", 32'({sram_cs, sram_rd, sram_wr}), 32'b110);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle();
    check_eq("rmw_rst_mem", mem[8], 32'hCAFEF00D);
    rst_n = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);

    // Reset coinciding with WR still commits.
    build_exp(1'b1, 2'b01, 1'b0, 32'h24, 32'h0000BEEF, dummy);
    send(1'b1, 2'b01, 1'b0, 32'h24, 32'h0000BEEF);
    @(posedge clk);
    #1;
    check_eq("wr_strobes", 32'({sram_cs, sram_rd, sram_wr}), 32'b101);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_idle();
    check_eq("wr_rst_mem", mem[9], ref_mem[9]);
    rst_n = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
